// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result bundle between the switch/key input logic and
// the alu_seq datapath.
//   start   - request a new operation (honoured only while busy=0)
//   op      - operation select, captured with start
//   a, b    - operands, captured with start
//   use_acc - take operand B from the current result instead of b
//   result  - registered result / accumulator
//   carry   - carry-out of the add operation
//   busy    - serial bit count in progress
//   done    - one-cycle completion pulse
// master drives the request side; slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             use_acc;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, use_acc,
        input  result, carry, busy, done
    );

    modport slave (
        input  start, op, a, b, use_acc,
        output result, carry, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered eight-operation ALU with an accumulator path.
// Logic ops and the add finish on the capture edge; the two bit-count ops
// (110 = ones in A, 111 = ones in A plus ones in B) shift the captured
// operands out one bit per clock and finish WIDTH edges after capture.
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high; clears all state
//   bus  - alu_seq_if slave modport (start/op/a/b/use_acc in,
//          result/carry/busy/done out)
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    // Wide enough to hold 2*WIDTH ones.
    localparam int CW = $clog2(2 * WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             both_q;   // op 111: count B bits as well
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             done_q;

    logic             busy;
    logic             capture;
    logic             serial_op;
    logic             last_bit;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH:0]   single_res;
    logic [CW-1:0]    cnt_next;

    // Single-cycle operations; bit WIDTH carries the add carry-out and is
    // zero for every other op, so it can be loaded into carry unconditionally.
    function automatic logic [WIDTH:0] alu_op(input logic [2:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            3'b000:  r = {1'b0, ~a | b};
            3'b001:  r = {1'b0, a | ~b};
            3'b010:  r = {1'b0, ~a};
            3'b011:  r = {1'b0, a & b};
            3'b100:  r = {1'b0, a} + {1'b0, b};
            3'b101:  r = {1'b0, ~(a | b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign busy       = (state_q == COUNT);
    assign capture    = bus.start && !busy;
    assign serial_op  = (bus.op[2:1] == 2'b11);
    assign last_bit   = (idx_q == LAST_IDX);
    // The accumulator is the result present before the capture edge.
    assign b_sel      = bus.use_acc ? result_q : bus.b;
    assign single_res = alu_op(bus.op, bus.a, b_sel);
    assign cnt_next   = cnt_q + CW'(a_q[0]) + CW'(both_q & b_q[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture && serial_op) state_d = COUNT;
            COUNT:   if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture stage / serial count stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            both_q   <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (capture) begin
                if (serial_op) begin
                    a_q    <= bus.a;
                    b_q    <= b_sel;
                    both_q <= bus.op[0];
                    cnt_q  <= '0;
                    idx_q  <= '0;
                end else begin
                    result_q <= single_res[WIDTH-1:0];
                    carry_q  <= single_res[WIDTH];
                    done_q   <= 1'b1;
                end
            end else if (busy) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                cnt_q <= cnt_next;
                idx_q <= idx_q + 1'b1;
                // Final bit folds straight into the result on this edge.
                if (last_bit) begin
                    result_q <= WIDTH'(cnt_next);
                    carry_q  <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.busy   = busy;
    assign bus.done   = done_q;
endmodule
